// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - buffered UART transmitter: input FIFO feeding a start/data/parity/stop framer
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 7,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                push, pop;
  logic                fifo_nonempty;
  logic [BAUD_W-1:0]   baud_cnt, baud_next;
  logic                baud_wrap;
  logic [BIT_W-1:0]    bit_cnt, bit_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                parity, parity_next;
  logic                tx_next;

  // Full is decoded from the registered count only, so a pop in the same
  // cycle never opens the input early.
  assign in_ready      = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign busy          = (state != IDLE);
  assign baud_wrap     = (baud_cnt == BAUD_LAST);

  // FIFO storage; entries are only read when occupancy says they are valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers (wrap naturally, depth is a power of two) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Framer state, datapath and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
      parity    <= parity_next;
      tx        <= tx_next;
    end
  end

  // Next state, FIFO pop and next line value (taken from the state being entered)
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity;
    baud_next   = (state == IDLE || baud_wrap) ? '0 : baud_cnt + BAUD_W'(1);

    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop         = 1'b1;
          shift_next  = mem[rd_ptr];
          parity_next = 1'b0;
          bit_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        if (baud_wrap) state_next = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_next  = shift_reg >> 1;
          parity_next = parity ^ shift_reg[0];
          if (bit_cnt == BIT_LAST) state_next = PARITY;
          else                     bit_next   = bit_cnt + BIT_W'(1);
        end
      end
      PARITY: begin
        if (baud_wrap) state_next = STOP;
      end
      STOP: begin
        if (baud_wrap) begin
          if (fifo_nonempty) begin
            // Chain straight into the next frame without an idle cycle
            pop         = 1'b1;
            shift_next  = mem[rd_ptr];
            parity_next = 1'b0;
            bit_next    = '0;
            state_next  = START;
          end else begin
            state_next  = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Buffered serial transmitter that is the sending end of the team's UART link. It accepts 7-bit words through a valid/ready handshake into a small FIFO and serialises each word onto a single line. The frame is start bit, 7 data bits LSB first, even parity, stop bit, at a programmable bit period. It drives the serial input of the existing receiver, and that receiver's error flag fires on a parity mismatch.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is ≥1.
- DATA_W, 7, payload bits per frame.
- FIFO_DEPTH, 4, word entries; must be a power of two, ≥2.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_data  input  DATA_W  word to transmit.
- in_ready  output  1  FIFO can accept a word; push occurs when in_valid && in_ready at a rising edge.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  a frame is on the line (any state other than IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered, excluding the word in flight.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and an occupancy counter.
  - in_ready = (fifo_count != FIFO_DEPTH), decoded from registered state only.
  - When full, in_ready stays 0 even in a cycle where a pop happens.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: at the first edge where fifo_count != 0.
  - On that edge, pop the head word into the shift register.
  - Clear the parity accumulator, bit counter and baud counter.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit, shift right and XOR the sent bit into parity.
  - After DATA_W bits, go to PARITY.
- PARITY: tx = XOR of all DATA_W data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
  - if fifo_count != 0, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. The state or bit advances on the wrap.
- With CLKS_PER_BIT=1, every state lasts exactly one cycle.
- Words accepted mid-frame are queued. They never disturb the frame in flight.

## Timing
- Reset values (take effect asynchronously while rst=1):
  - tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, pointers=0.
  - Pushes are ignored while rst=1.
- Reset mid-frame: the frame is abandoned immediately, tx returns high and queued words are discarded. No partial stop bit is emitted.
- Latency: the push edge into an empty, idle block is edge N.
  - Edge N+1: pop; tx falls and busy rises.
  - tx and busy change on the same edges.
- Frame length: exactly (DATA_W+3)*CLKS_PER_BIT cycles of busy=1.
- Back-to-back frames: the next start bit begins on the edge right after the last stop-bit cycle; busy stays 1 throughout.
- busy falls on the edge that ends the stop bit, when the FIFO is empty at that point.
- fifo_count:
  - increments on the push edge;
  - decrements on the pop edge, which is the same edge tx goes low for the start bit.

## Test plan
- Reset, CLKS_PER_BIT=4, push 7'h55 into an idle block.
  - tx must read, in 4-cycle bits: 0, 1,0,1,0,1,0,1, 0 (parity), 1 (stop).
  - busy is high for exactly 40 cycles, starting one edge after the push.
- Parity check:
  - 7'h7F gives parity bit 1.
  - 7'h00 gives parity bit 0.
  - Loop tx through the receiver; its output must equal the input and the error flag must stay 0.
- Overflow, FIFO_DEPTH=4: hold in_valid with 6 distinct words while one frame is in flight.
  - in_ready drops after 4 buffered words and fifo_count reaches 4.
  - No word is lost or duplicated, and all are sent in order with no idle gap between frames.
- Simultaneous push and pop: push on exactly the STOP->START pop edge with fifo_count=2.
  - fifo_count stays at 2.
  - Pointer wrap is exercised by pushing ≥9 words total.
- Reset mid-frame: assert rst during the DATA bit 3 of 7'h2A with 2 words queued.
  - tx goes 1, busy 0 and fifo_count 0 immediately.
  - After release, a new push to 7'h11 produces a clean, correct frame.
- Boundary case CLKS_PER_BIT=1: stream 3 words.
  - Each frame lasts 10 cycles, and the 3 frames form 30 contiguous busy cycles.
